// File: rtl/issue_select_ctrl.sv
// issue_select_ctrl
// Picks a free issue slot for each dispatched micro-op, keeps a pairwise age
// matrix over the slots, grants the oldest ready slot to the single execute
// unit and holds off further grants while a multi-cycle op occupies the unit.
module issue_select_ctrl #(
    parameter int NUM_SLOTS = 8,
    parameter int LAT_W     = 3,
    parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic [NUM_SLOTS-1:0]       slot_valid_i,
    input  logic [NUM_SLOTS-1:0]       slot_request_i,
    input  logic [NUM_SLOTS*LAT_W-1:0] slot_lat_i,
    output logic [NUM_SLOTS-1:0]       slot_grant_o,
    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    output logic [NUM_SLOTS-1:0]       alloc_we_o,
    output logic [IDX_W-1:0]           disp_slot_o,
    output logic                       issue_valid_o,
    output logic [IDX_W-1:0]           issue_slot_o,
    output logic                       fu_busy_o
);

    // older_q[i][j] = 1 : slot i was allocated before slot j. Diagonal unused.
    logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] older_q, older_d;
    logic [LAT_W-1:0]                    busy_cnt_q, busy_cnt_d;
    logic                                issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]                    issue_slot_q, issue_slot_d;

    logic [NUM_SLOTS-1:0] free_slots;
    logic [NUM_SLOTS-1:0] eligible;
    logic [NUM_SLOTS-1:0] winner;
    logic                 grant_en;
    logic                 alloc;
    logic [IDX_W-1:0]     grant_idx;
    logic [LAT_W-1:0]     grant_lat;

    assign free_slots   = ~slot_valid_i;
    assign eligible     = slot_request_i & slot_valid_i;
    assign fu_busy_o    = (busy_cnt_q != '0);
    assign disp_ready_o = (|free_slots) & ~flush_i & reset;
    assign alloc        = disp_valid_i & disp_ready_o;
    // reset gates the grant so nothing reaches the slots while the controller is held
    assign grant_en     = ~fu_busy_o & ~flush_i & reset;
    assign slot_grant_o = winner & {NUM_SLOTS{grant_en}};

    assign issue_valid_o = issue_valid_q;
    assign issue_slot_o  = issue_slot_q;

    // Lowest-index free slot; index 0 when the queue is full
    always_comb begin
        disp_slot_o = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_slots[i]) disp_slot_o = IDX_W'(i);
        end
    end

    // One-hot write enable to the slot being filled this cycle
    always_comb begin
        alloc_we_o = '0;
        if (alloc) alloc_we_o = NUM_SLOTS'(1) << disp_slot_o;
    end

    // Oldest eligible slot: older than every other eligible slot. Since the
    // matrix never holds both older[i][j] and older[j][i], at most one wins.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            winner[i] = eligible[i];
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if ((j != i) && eligible[j] && !older_q[i][j]) winner[i] = 1'b0;
            end
        end
    end

    // Encode the granted slot and pick up its latency field
    always_comb begin
        grant_idx = '0;
        grant_lat = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_grant_o[i]) begin
                grant_idx = IDX_W'(i);
                grant_lat = slot_lat_i[i*LAT_W +: LAT_W];
            end
        end
    end

    // Next state: age matrix, busy countdown and the registered issue report
    always_comb begin
        older_d       = older_q;
        busy_cnt_d    = busy_cnt_q;
        issue_valid_d = |slot_grant_o;
        issue_slot_d  = grant_idx;
        if (flush_i) begin
            older_d       = '0;
            busy_cnt_d    = '0;
            issue_valid_d = 1'b0;
        end else begin
            // newly allocated slot becomes the youngest
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (alloc_we_o[k]) begin
                    for (int j = 0; j < NUM_SLOTS; j++) begin
                        older_d[k][j] = 1'b0;
                        if (j != k) older_d[j][k] = 1'b1;
                    end
                end
            end
            // latency 0 behaves as 1, so single-cycle ops never raise busy
            if (|slot_grant_o) begin
                busy_cnt_d = (grant_lat == '0) ? '0 : grant_lat - LAT_W'(1);
            end else if (busy_cnt_q != '0) begin
                busy_cnt_d = busy_cnt_q - LAT_W'(1);
            end
        end
    end

    // State registers; async reset clears any in-flight stall immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            older_q       <= '0;
            busy_cnt_q    <= '0;
            issue_valid_q <= 1'b0;
            issue_slot_q  <= '0;
        end else begin
            older_q       <= older_d;
            busy_cnt_q    <= busy_cnt_d;
            issue_valid_q <= issue_valid_d;
            issue_slot_q  <= issue_slot_d;
        end
    end

endmodule

// File: tb/tb_issue_select_ctrl.sv
// Bench for issue_select_ctrl: directed stimulus with a behavioural slot
// array; expected allocations, grants and issue reports go into queues that
// a negedge monitor drains whenever the DUT presents the matching output.
module tb_issue_select_ctrl;
    localparam int N  = 8;
    localparam int LW = 3;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          disp_valid = 1'b0;
    logic [N-1:0]  sv = '0;
    logic [N-1:0]  req = '0;
    logic [N*LW-1:0] lat = '0;

    logic [N-1:0]  slot_grant;
    logic          disp_ready;
    logic [N-1:0]  alloc_we;
    logic [IW-1:0] disp_slot;
    logic          issue_valid;
    logic [IW-1:0] issue_slot;
    logic          fu_busy;

    issue_select_ctrl #(.NUM_SLOTS(N), .LAT_W(LW)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush),
        .slot_valid_i  (sv),
        .slot_request_i(req),
        .slot_lat_i    (lat),
        .slot_grant_o  (slot_grant),
        .disp_valid_i  (disp_valid),
        .disp_ready_o  (disp_ready),
        .alloc_we_o    (alloc_we),
        .disp_slot_o   (disp_slot),
        .issue_valid_o (issue_valid),
        .issue_slot_o  (issue_slot),
        .fu_busy_o     (fu_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q_alloc[$];
    int q_grant[$];
    int q_issue[$];
    logic [N-1:0] a_s, g_s;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // advance one cycle; slots fill on alloc_we and drop one cycle after grant
    task automatic adv();
        a_s = alloc_we;
        g_s = slot_grant;
        @(posedge clk);
        #1;
        sv = (sv | a_s) & ~g_s;
    endtask

    task automatic set_lat(input int i, input int v);
        lat[i*LW +: LW] = LW'(v);
    endtask

    task automatic exp_alloc(input int k);
        q_alloc.push_back(k);
    endtask

    task automatic exp_grant(input int k);
        q_grant.push_back(k);
        q_issue.push_back(k);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        int e;
        if (reset) begin
            if (alloc_we != '0) begin
                if (q_alloc.size() == 0) chk("alloc_unexpected", int'(alloc_we), 0);
                else begin
                    e = q_alloc.pop_front();
                    chk("alloc_we", int'(alloc_we), 1 << e);
                end
            end
            if (slot_grant != '0) begin
                if (q_grant.size() == 0) chk("grant_unexpected", int'(slot_grant), 0);
                else begin
                    e = q_grant.pop_front();
                    chk("slot_grant", int'(slot_grant), 1 << e);
                end
            end
            if (issue_valid) begin
                if (q_issue.size() == 0) chk("issue_unexpected", int'(issue_slot) + 256, 0);
                else begin
                    e = q_issue.pop_front();
                    chk("issue_slot", int'(issue_slot), e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) set_lat(i, 1);
        // reset: slot 0 alone eligible and dispatch pending, yet all held off
        sv = 8'h01; req = 8'h01; disp_valid = 1'b1;
        #7;
        chk("rst_ready", int'(disp_ready), 0);
        chk("rst_alloc", int'(alloc_we), 0);
        chk("rst_grant", int'(slot_grant), 0);
        chk("rst_issue_valid", int'(issue_valid), 0);
        chk("rst_issue_slot", int'(issue_slot), 0);
        chk("rst_busy", int'(fu_busy), 0);
        @(posedge clk); #1;
        sv = '0; req = '0;
        reset = 1'b1;

        // fill in index order
        for (int c = 0; c < N; c++) begin
            exp_alloc(c);
            settle();
            chk("fill_ready", int'(disp_ready), 1);
            chk("fill_slot", int'(disp_slot), c);
            adv();
        end
        settle();
        chk("full_ready", int'(disp_ready), 0);
        chk("full_slot", int'(disp_slot), 0);
        chk("full_alloc", int'(alloc_we), 0);
        disp_valid = 1'b0;
        adv();

        // latency-1 back-to-back grants
        req = 8'h18;
        exp_grant(3);
        settle(); chk("lat1_busy_a", int'(fu_busy), 0); adv();
        exp_grant(4);
        settle(); chk("lat1_busy_b", int'(fu_busy), 0); chk("lat1_grant_b", int'(slot_grant), 8'h10); adv();
        req = '0;
        settle(); chk("lat1_busy_c", int'(fu_busy), 0); adv();
        settle(); chk("empty_issue_valid", int'(issue_valid), 0); adv();
        disp_valid = 1'b1;
        exp_alloc(3); settle(); adv();
        exp_alloc(4); settle(); adv();

        // age select: allocate 3, 1, 6 then request 1 and 6
        sv = sv & ~8'h08; exp_alloc(3); settle(); adv();
        sv = sv & ~8'h02; exp_alloc(1); settle(); adv();
        sv = sv & ~8'h40; exp_alloc(6); settle(); adv();
        disp_valid = 1'b0;
        req = 8'h42;
        exp_grant(1);
        settle(); chk("age_grant", int'(slot_grant), 8'h02); adv();
        req = '0;
        settle(); chk("age_issue_valid", int'(issue_valid), 1); chk("age_issue_slot", int'(issue_slot), 1); adv();
        disp_valid = 1'b1; exp_alloc(1); settle(); adv(); disp_valid = 1'b0;

        // multi-cycle stall: slot 2 lat 4, slot 5 waiting
        set_lat(2, 4); set_lat(5, 1);
        req = 8'h24;
        exp_grant(2);
        settle(); chk("stall_busy_pre", int'(fu_busy), 0); adv();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("stall_busy", int'(fu_busy), 1);
            chk("stall_grant", int'(slot_grant), 0);
            adv();
        end
        exp_grant(5);
        settle(); chk("stall_busy_end", int'(fu_busy), 0); chk("stall_grant5", int'(slot_grant), 8'h20); adv();
        req = '0;
        settle(); adv();

        // flush during a lat-5 stall with one free slot
        disp_valid = 1'b1;
        exp_alloc(2); settle(); adv();
        exp_alloc(5); settle(); adv();
        disp_valid = 1'b0;
        set_lat(0, 5);
        req = 8'h01;
        exp_grant(0);
        settle(); adv();
        req = 8'h10;
        settle();
        chk("fl_busy_pre", int'(fu_busy), 1);
        chk("fl_ready_pre", int'(disp_ready), 1);
        chk("fl_grant_pre", int'(slot_grant), 0);
        adv();
        flush = 1'b1; disp_valid = 1'b1;
        settle();
        chk("fl_grant", int'(slot_grant), 0);
        chk("fl_ready", int'(disp_ready), 0);
        chk("fl_alloc", int'(alloc_we), 0);
        adv();
        flush = 1'b0; disp_valid = 1'b0; req = '0;
        settle();
        chk("post_fl_busy", int'(fu_busy), 0);
        chk("post_fl_ready", int'(disp_ready), 1);
        chk("post_fl_issue_valid", int'(issue_valid), 0);
        adv();

        // simultaneous grant and allocate; latency 0 on the granted slot
        sv = 8'h7f; set_lat(0, 0); req = 8'h01; disp_valid = 1'b1;
        exp_alloc(7); exp_grant(0);
        settle(); chk("sim_alloc", int'(alloc_we), 8'h80); chk("sim_grant", int'(slot_grant), 8'h01); adv();
        disp_valid = 1'b0; req = '0;
        settle(); chk("lat0_busy", int'(fu_busy), 0); adv();

        // reset in the middle of a lat-7 op
        sv = 8'h02; req = 8'h02; set_lat(1, 7);
        q_grant.push_back(1);
        settle(); adv();
        req = '0;
        chk("mid_busy", int'(fu_busy), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", int'(fu_busy), 0);
        chk("mid_rst_issue", int'(issue_valid), 0);
        chk("mid_rst_ready", int'(disp_ready), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        settle();
        chk("after_rst_busy", int'(fu_busy), 0);
        chk("after_rst_ready", int'(disp_ready), 1);
        adv();

        chk("q_alloc_empty", q_alloc.size(), 0);
        chk("q_grant_empty", q_grant.size(), 0);
        chk("q_issue_empty", q_issue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/issue_select_ctrl.md
# issue_select_ctrl

Select-and-allocate controller for an issue queue of `NUM_SLOTS` issue slots feeding one execute unit.
- Each cycle it picks a free slot for an incoming dispatched micro-op.
- It tracks relative slot age with an age matrix.
- Among ready slots, it grants the oldest one to the execute unit.
- It stalls selection while a multi-cycle operation occupies the unit.

It sits between the dispatch stage, the array of issue slots (request/valid in, grant/write-enable out) and the execute stage.

## Interface
- `NUM_SLOTS`, 8, number of issue slots (2..16)
- `LAT_W`, 3, width of per-slot execution latency field
- `IDX_W`, $clog2(NUM_SLOTS), slot index width (derived)

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous pipeline kill; clears scheduler state
- `slot_valid`  in  NUM_SLOTS  per-slot occupied flag (slot `valid_out`)
- `slot_request`  in  NUM_SLOTS  per-slot ready-to-issue (slot `request`)
- `slot_lat`  in  NUM_SLOTS*LAT_W  per-slot execution latency; slot i at bits [i*LAT_W +: LAT_W]
- `slot_grant`  out  NUM_SLOTS  one-hot grant; slot clears itself at next edge
- `disp_valid`  in  1  dispatch presents a micro-op
- `disp_ready`  out  1  a free slot exists and the controller accepts
- `alloc_we`  out  NUM_SLOTS  one-hot write enable to the allocated slot
- `disp_slot`  out  IDX_W  index of the allocated slot
- `issue_valid`  out  1  registered: an op was granted last cycle
- `issue_slot`  out  IDX_W  registered index of that op
- `fu_busy`  out  1  execute unit occupied by a multi-cycle op

## Operation
- **Free-slot search**
  - Free vector: `~slot_valid`.
  - `disp_slot` is the lowest-index free slot.
  - `disp_ready` = (any free) & !flush & reset deasserted.
- **Allocation**
  - Occurs when `disp_valid & disp_ready`.
  - `alloc_we[disp_slot]`=1, otherwise all zero.
- **Age matrix** `older[i][j]` (i≠j), 1 means slot i is older than slot j.
  - On allocation of slot k at the clock edge: `older[k][*]`=0 and `older[*][k]`=1, so k becomes youngest.
  - No other bits change.
- **Select**
  - A slot is eligible when `slot_request[i] & slot_valid[i]`.
  - The winner is the eligible i with `older[i][j]`=1 for every other eligible j.
  - Exactly one winner exists whenever any slot is eligible.
  - Grant is suppressed when `fu_busy` or `flush`.
  - `slot_grant` is combinational and one-hot or zero.
- **Busy counter** (LAT_W bits)
  - On a grant of slot i with L = `slot_lat[i]`: load max(L,1)-1. L=0 is treated as 1.
  - The counter decrements each cycle while nonzero.
  - `fu_busy` = (count != 0).
  - A latency-1 op leaves `fu_busy` at 0, so back-to-back grants are allowed.
- **Flush**
  - At the edge with `flush`=1: busy count→0, age matrix→0, `issue_valid`→0.
  - While `flush` is high: no grant, no allocation.
- **Simultaneous allocation and grant** are allowed in the same cycle.
  - A slot being granted is still valid in that cycle, so it is never the allocated slot.

## Timing
- Grant and allocation decisions are combinational within the cycle.
- All state updates on `posedge clk`.
- `issue_valid`/`issue_slot` = registered copy of (any grant, encoded grant index): 1-cycle latency from grant.
- The slot's `slot_valid` drops one cycle after grant.
  - The controller relies on this.
  - A re-request in the grant cycle is impossible because the grant is one-hot.
- **Reset** (async, `reset`=0):
  - age matrix 0, busy count 0, `issue_valid`=0, `issue_slot`=0.
  - `slot_grant`=0, `alloc_we`=0, `disp_ready`=0 while reset is asserted.
- After reset release, `disp_ready`=1 if any `slot_valid` bit is 0.
- **Full queue** (all `slot_valid`=1): `disp_ready`=0, `alloc_we`=0, `disp_slot`=0.
- **Empty queue**: `slot_grant`=0, `issue_valid` deasserts next cycle.
- **Reset mid multi-cycle op**: counter cleared immediately; no residual stall.

## Test plan
- **Fill and order:** reset, empty queue, `disp_valid`=1 for 8 cycles.
  - `alloc_we` = 0x01,0x02,…,0x80 in order.
  - `disp_ready`=0 on cycle 9.
- **Age select:** allocate slots in order 3,1,6 (others held valid), then raise `slot_request` for 1 and 6 together.
  - `slot_grant`=0x02.
  - Next cycle `issue_valid`=1, `issue_slot`=1.
- **Multi-cycle stall:** grant slot 2 with `slot_lat`=4 while slot 5 is requesting.
  - `fu_busy` high for 3 cycles.
  - `slot_grant[5]` asserts on the 4th cycle after the slot 2 grant.
- **Latency 0/1:** two ready slots, both with lat=1.
  - Grants in consecutive cycles.
  - `fu_busy` never asserts.
- **Flush:** flush during a lat=5 stall with one free slot.
  - No grant, `disp_ready`=0 during flush.
  - Next cycle `fu_busy`=0 and `disp_ready`=1.
- **Simultaneous grant+allocate:** queue full except slot 7, slot 0 granted, `disp_valid`=1.
  - `alloc_we`=0x80 and `slot_grant`=0x01 in the same cycle.
